// File: rtl/mem_burst_arbiter_if.sv
// Burst bus bundle between four video requesters, the arbiter and SDRAM.
// slave: arbiter view; master: requester/memory environment view.
interface mem_burst_arbiter_if #(
  parameter int ADDR_W = 22
);
  logic [3:0]          req_as;
  logic [4*ADDR_W-1:0] req_address;
  logic [3:0]          req_burstdata_valid;
  logic [3:0]          req_bus_ack;
  logic [15:0]         din;
  logic                mem_as;
  logic [ADDR_W-1:0]   mem_address;
  logic [15:0]         mem_din;
  logic                mem_burstdata_valid;
  logic                mem_bus_ack;
  logic [1:0]          grant;
  logic                busy;

  modport slave (
    input  req_as, req_address,
    input  mem_din, mem_burstdata_valid,
    input  mem_bus_ack,
    output req_burstdata_valid, req_bus_ack,
    output din, mem_as, mem_address,
    output grant, busy
  );

  modport master (
    output req_as, req_address,
    output mem_din, mem_burstdata_valid,
    output mem_bus_ack,
    input  req_burstdata_valid, req_bus_ack,
    input  din, mem_as, mem_address,
    input  grant, busy
  );
endinterface

// File: rtl/mem_burst_arbiter.sv
// Shares one SDRAM burst port among 4 requesters: 0/1 fixed priority,
// 2/3 round-robin with starvation promotion. Ports: clk, reset, bus.
module mem_burst_arbiter #(
  parameter int ADDR_W   = 22,
  parameter int MAX_WAIT = 8
) (
  input logic                 clk,
  input logic                 reset,
  mem_burst_arbiter_if.slave  bus
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_BURST = 1'b1;
  localparam logic [3:0] WAIT_LIM = 4'(MAX_WAIT);

  logic [0:0]        state_q, state_d;
  logic [1:0]        grant_q, grant_d;
  logic [1:0]        rr_last_q, rr_last_d;
  logic [3:0]        wait_q, wait_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  logic       low_pend;
  logic       any_req;
  logic       promote;
  logic [1:0] low_pick;
  logic [1:0] win;

  assign low_pend = bus.req_as[2] | bus.req_as[3];
  assign any_req  = |bus.req_as;
  assign promote  = low_pend && (wait_q == WAIT_LIM);

  // Low pair: start searching after the last low owner.
  always_comb begin
    low_pick = 2'd2;
    if (rr_last_q == 2'd2) begin
      low_pick = bus.req_as[3] ? 2'd3 : 2'd2;
    end else begin
      low_pick = bus.req_as[2] ? 2'd2 : 2'd3;
    end
  end

  always_comb begin
    win = low_pick;
    if (promote)            win = low_pick;
    else if (bus.req_as[0]) win = 2'd0;
    else if (bus.req_as[1]) win = 2'd1;
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rr_last_d = rr_last_q;
    wait_d    = wait_q;
    addr_d    = addr_q;
    if (state_q == S_IDLE) begin
      if (any_req) begin
        state_d = S_BURST;
        grant_d = win;
        addr_d  = bus.req_address[int'(win)*ADDR_W +: ADDR_W];
        if (win[1]) begin
          rr_last_d = win;
          wait_d    = 4'd0;
        end else if (low_pend) begin
          wait_d = (wait_q == WAIT_LIM) ? wait_q : wait_q + 4'd1;
        end else begin
          wait_d = 4'd0;
        end
      end
    end else if (bus.mem_bus_ack) begin
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      grant_q   <= 2'd0;
      rr_last_q <= 2'd3;
      wait_q    <= 4'd0;
      addr_q    <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      rr_last_q <= rr_last_d;
      wait_q    <= wait_d;
      addr_q    <= addr_d;
    end
  end

  logic owned;
  assign owned = (state_q == S_BURST);

  assign bus.mem_as      = owned;
  assign bus.busy        = owned;
  assign bus.grant       = grant_q;
  assign bus.mem_address = addr_q;
  assign bus.din         = bus.mem_din;

  // Memory strobes reach only the owner; anything seen in IDLE is dropped.
  assign bus.req_burstdata_valid =
    (owned && bus.mem_burstdata_valid) ? (4'b0001 << grant_q) : 4'b0000;
  assign bus.req_bus_ack =
    (owned && bus.mem_bus_ack) ? (4'b0001 << grant_q) : 4'b0000;

  a_hold_as: assert property (
    @(posedge clk) disable iff (reset)
    owned |-> bus.req_as[grant_q]
  ) else $error("req_as dropped while granted");

endmodule

// File: doc/mem_burst_arbiter.md
Name: mem_burst_arbiter

Overview:
- Shares one SDRAM burst port between four video-path requesters.
- Requesters 0/1 are pixel fetchers (ch0/ch1): fixed high priority.
- Requesters 2/3 are the ICA/DCA controllers (ch0/ch1): round-robin between themselves, with a starvation guard.
- Each requester sees the same as/address/burstdata_valid/bus_ack protocol as a private bus. One burst (4 words) is granted per arbitration.

Parameters:
- ADDR_W, 22, word-address width of each requester and of the memory port.
- MAX_WAIT, 8, number of consecutive high-priority grants after which a waiting low-priority requester is promoted (range 1..15).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- req_as  in  4  per-requester address strobe, level; held until that requester's bus_ack.
- req_address  in  4*ADDR_W  requester i uses bits [i*ADDR_W +: ADDR_W]; stable while req_as[i]=1.
- req_burstdata_valid  out  4  per-requester word strobe; only the granted bit can be 1.
- req_bus_ack  out  4  per-requester end-of-burst pulse; only the granted bit can be 1.
- din  out  16  read data, broadcast to all requesters (= mem_din).
- mem_as  out  1  burst request to the memory controller.
- mem_address  out  ADDR_W  burst start address.
- mem_din  in  16  read data from memory.
- mem_burstdata_valid  in  1  one pulse per returned 16-bit word.
- mem_bus_ack  in  1  pulse on the final cycle of a burst.
- grant  out  2  index of the current or last owner.
- busy  out  1  high while a burst is owned.

Behaviour:
- Reset values: mem_as=0, mem_address=0, grant=0, busy=0, req_burstdata_valid=0, req_bus_ack=0, rr_last=3, wait_cnt=0, state IDLE.
- Reset mid-burst: abandon the burst immediately; ignore any later mem_burstdata_valid/mem_bus_ack until a new grant.
- States: IDLE, BURST.
- IDLE, no req_as set: remain in IDLE.
- IDLE, any req_as set, winner selection in this order:
  - (a) a promoted low requester, if wait_cnt==MAX_WAIT;
  - (b) requester 0, then requester 1;
  - (c) requesters 2/3 round-robin, starting after rr_last.
- IDLE, on selection (registered):
  - grant<=winner, mem_address<=req_address[winner], mem_as<=1, busy<=1;
  - go to BURST.
  - Latency: req_as seen in cycle N gives mem_as=1 in cycle N+1.
- BURST:
  - req_burstdata_valid[grant] = mem_burstdata_valid (combinational, same cycle).
  - req_bus_ack[grant] = mem_bus_ack (combinational).
- BURST, on mem_bus_ack: mem_as<=0, busy<=0, return to IDLE.
  - The earliest next grant is decided in IDLE on cycle ack+1, so back-to-back bursts have a 1-cycle gap.
  - A requester that holds req_as=1 with a new address after its ack (DCA streaming) re-enters arbitration as a fresh request; it is not re-granted automatically.
- Round robin: when requester 2 or 3 is granted, rr_last<=grant.
- Starvation counter (wait_cnt, 4 bits), updated at each grant:
  - If req_as[2]|req_as[3] is pending and the winner is 0 or 1: wait_cnt<=wait_cnt+1, saturating at MAX_WAIT.
  - If the winner is 2 or 3: wait_cnt<=0.
  - With no low requester pending: wait_cnt<=0.
- Simultaneous events:
  - mem_bus_ack and new req_as edges in the same cycle: new requests are only evaluated in IDLE.
  - mem_burstdata_valid and mem_bus_ack in the same cycle: both are routed.
- Words per burst are not counted; mem_bus_ack alone ends ownership. mem_burstdata_valid while IDLE is dropped.
- A requester deasserting req_as while granted is a protocol violation: assert in simulation; ownership is still held until ack.

Test Plan:
- Only req_as[2]=1 at cycle 10, addr 0x000400 → mem_as=1, mem_address=0x000400 at cycle 11. Four mem_burstdata_valid pulses appear on req_burstdata_valid[2] only. mem_bus_ack → req_bus_ack[2] pulse, mem_as=0 next cycle.
- req_as[0] and req_as[3] both set in IDLE → grant=0 first; grant=3 on the cycle after 0's ack+1.
- req_as[2] and req_as[3] held continuously with new addresses after each ack → grants alternate 2,3,2,3; each re-request adds a 1-cycle IDLE gap.
- req_as[0] held continuously, req_as[2] pending, MAX_WAIT=8 → 8 grants to 0, then grant=2, then wait_cnt=0 and grant returns to 0.
- reset asserted mid-burst after 2 words → mem_as=0, busy=0, grant=0 next cycle. Remaining mem_burstdata_valid/mem_bus_ack produce no req_* pulses.
- mem_burstdata_valid pulsed while IDLE → all req_burstdata_valid stay 0; state unchanged.
